// File: rtl/out_port_fifo_if.sv
// CPU-write / device-drain bundle for out_port_fifo.
// OUT_PORT_FIFO_LAST_EN adds the last_data readback bus.
interface out_port_fifo_if #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 2,
   parameter int SEL_W    = 3
);
   logic [WIDTH-1:0]          BusMuxOut;
   logic                      Out_portIn;
   logic [SEL_W-1:0]          out_sel;
   logic                      ovf_clr;
   logic [CHANNELS*WIDTH-1:0] dev_data;
   logic [CHANNELS-1:0]       dev_valid;
   logic [CHANNELS-1:0]       dev_ready;
   logic [CHANNELS-1:0]       port_full;
   logic [CHANNELS-1:0]       port_empty;
   logic [CHANNELS-1:0]       port_ovf;
`ifdef OUT_PORT_FIFO_LAST_EN
   logic [CHANNELS*WIDTH-1:0] last_data;

   modport master (
      output BusMuxOut, Out_portIn, out_sel, ovf_clr, dev_ready,
      input  dev_data, dev_valid, port_full, port_empty, port_ovf, last_data
   );
   modport slave (
      input  BusMuxOut, Out_portIn, out_sel, ovf_clr, dev_ready,
      output dev_data, dev_valid, port_full, port_empty, port_ovf, last_data
   );
`else
   modport master (
      output BusMuxOut, Out_portIn, out_sel, ovf_clr, dev_ready,
      input  dev_data, dev_valid, port_full, port_empty, port_ovf
   );
   modport slave (
      input  BusMuxOut, Out_portIn, out_sel, ovf_clr, dev_ready,
      output dev_data, dev_valid, port_full, port_empty, port_ovf
   );
`endif
endinterface

// File: rtl/out_port_fifo.sv
// Multi-channel output port: per-channel circular FIFOs written from the CPU bus, drained by valid/ready.
// Optional OUT_PORT_FIFO_LAST_EN keeps a per-channel copy of the last accepted word.
module out_port_fifo #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 2,
   parameter int DEPTH    = 4,
   parameter int SEL_W    = 3
) (
   input  logic           clock,
   input  logic           clear,
   out_port_fifo_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [WIDTH-1:0] mem [DEPTH];
      logic [PTR_W-1:0] wptr;
      logic [PTR_W-1:0] rptr;
      logic [CNT_W-1:0] count;
      logic             ovf_q;
      logic             full;
      logic             empty;
      logic             sel_hit;
      logic             push;
      logic             pop;
      logic             drop;

      assign full  = (count == CNT_W'(DEPTH));
      assign empty = (count == '0);
      // c < CHANNELS always, so out-of-range selects never match any channel
      assign sel_hit = bus.Out_portIn && (bus.out_sel == SEL_W'(c));
      assign pop     = !empty && bus.dev_ready[c];
      assign push    = sel_hit && (!full || pop);
      assign drop    = sel_hit && full && !pop;

      always_ff @(posedge clock) begin
         if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         end else begin
            if (push) begin
               mem[wptr] <= bus.BusMuxOut;
               wptr      <= wptr + PTR_W'(1);
            end
            if (pop) rptr <= rptr + PTR_W'(1);
            case ({push, pop})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
            if (drop)             ovf_q <= 1'b1;
            else if (bus.ovf_clr) ovf_q <= 1'b0;
         end
      end

      assign bus.dev_data[c*WIDTH +: WIDTH] = mem[rptr];
      assign bus.dev_valid[c]  = !empty;
      assign bus.port_full[c]  = full;
      assign bus.port_empty[c] = empty;
      assign bus.port_ovf[c]   = ovf_q;

`ifdef OUT_PORT_FIFO_LAST_EN
      logic [WIDTH-1:0] last_q;

      always_ff @(posedge clock) begin
         if (clear)     last_q <= '0;
         else if (push) last_q <= bus.BusMuxOut;
      end

      assign bus.last_data[c*WIDTH +: WIDTH] = last_q;
`endif
   end
endmodule

// File: tb/tb_out_port_fifo.sv
// Self-checking bench for out_port_fifo: vector table, hand sequences and a queue scoreboard under random traffic.
module tb_out_port_fifo;
   localparam int W  = 32;
   localparam int CH = 2;
   localparam int DP = 4;
   localparam int SW = 3;

   logic clock = 1'b0;
   logic clear;
   always #5 clock = ~clock;

   out_port_fifo_if #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) bus ();

   out_port_fifo #(.WIDTH(W), .CHANNELS(CH), .DEPTH(DP), .SEL_W(SW)) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [W-1:0]  mq [CH][$];
   logic [CH-1:0] movf;
   logic [W-1:0]  mlast [CH];

   typedef struct {
      logic          we;
      logic [SW-1:0] sel;
      logic [W-1:0]  d;
      logic [CH-1:0] rdy;
      logic          oc;
      logic [CH-1:0] v, f, e, o;
      logic [W-1:0]  d0, d1;
   } vec_t;

   vec_t tbl [24];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_state();
      logic [CH-1:0] ev, ef, ee;
      for (int c = 0; c < CH; c++) begin
         ev[c] = (mq[c].size() > 0);
         ef[c] = (mq[c].size() == DP);
         ee[c] = (mq[c].size() == 0);
      end
      check("sb_valid", 64'(bus.dev_valid), 64'(ev));
      check("sb_full",  64'(bus.port_full), 64'(ef));
      check("sb_empty", 64'(bus.port_empty), 64'(ee));
      check("sb_ovf",   64'(bus.port_ovf), 64'(movf));
      for (int c = 0; c < CH; c++)
         if (ev[c]) check("sb_head", 64'(bus.dev_data[c*W +: W]), 64'(mq[c][0]));
`ifdef OUT_PORT_FIFO_LAST_EN
      for (int c = 0; c < CH; c++)
         check("sb_last", 64'(bus.last_data[c*W +: W]), 64'(mlast[c]));
`endif
   endtask

   // One clock: drive inputs, update the scoreboard, advance past the edge, compare.
   task automatic step(input logic we, input logic [SW-1:0] sel, input logic [W-1:0] d,
                       input logic [CH-1:0] rdy, input logic oc, input logic clr);
      logic [CH-1:0] popping;
      logic [CH-1:0] dropped;
      int            pre [CH];
      bus.Out_portIn = we;
      bus.out_sel    = sel;
      bus.BusMuxOut  = d;
      bus.dev_ready  = rdy;
      bus.ovf_clr    = oc;
      clear          = clr;
      popping = '0;
      dropped = '0;
      if (clr) begin
         for (int c = 0; c < CH; c++) begin
            mq[c].delete();
            mlast[c] = '0;
         end
         movf = '0;
      end else begin
         for (int c = 0; c < CH; c++) begin
            pre[c] = mq[c].size();
            if (rdy[c] && pre[c] > 0) begin
               popping[c] = 1'b1;
               check("pop_data", 64'(bus.dev_data[c*W +: W]), 64'(mq[c][0]));
               void'(mq[c].pop_front());
            end
         end
         if (we && int'(sel) < CH) begin
            if (pre[sel] < DP || popping[sel]) begin
               mq[sel].push_back(d);
               mlast[sel] = d;
            end else begin
               dropped[sel] = 1'b1;
            end
         end
         for (int c = 0; c < CH; c++) begin
            if (dropped[c])  movf[c] = 1'b1;
            else if (oc)     movf[c] = 1'b0;
         end
      end
      @(posedge clock);
      #1;
      check_state();
   endtask

   function automatic vec_t mk(input logic we, input logic [SW-1:0] sel, input logic [W-1:0] d,
                               input logic [CH-1:0] rdy, input logic oc,
                               input logic [CH-1:0] v, input logic [CH-1:0] f,
                               input logic [CH-1:0] e, input logic [CH-1:0] o,
                               input logic [W-1:0] d0, input logic [W-1:0] d1);
      vec_t r;
      r.we = we; r.sel = sel; r.d = d; r.rdy = rdy; r.oc = oc;
      r.v = v; r.f = f; r.e = e; r.o = o; r.d0 = d0; r.d1 = d1;
      return r;
   endfunction

   initial begin
      //            we sel data   rdy   oc  valid  full   empty  ovf    d0     d1
      tbl[0]  = mk(1, 1, 32'h63, 2'b00, 0, 2'b10, 2'b00, 2'b01, 2'b00, 32'h0, 32'h63);
      tbl[1]  = mk(1, 0, 32'h1,  2'b00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 32'h1, 32'h63);
      tbl[2]  = mk(1, 0, 32'h2,  2'b00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 32'h1, 32'h63);
      tbl[3]  = mk(1, 0, 32'h3,  2'b00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 32'h1, 32'h63);
      tbl[4]  = mk(1, 0, 32'h4,  2'b00, 0, 2'b11, 2'b01, 2'b00, 2'b00, 32'h1, 32'h63);
      tbl[5]  = mk(1, 0, 32'h5,  2'b00, 0, 2'b11, 2'b01, 2'b00, 2'b01, 32'h1, 32'h63);
      tbl[6]  = mk(0, 0, 32'h0,  2'b11, 0, 2'b01, 2'b00, 2'b10, 2'b01, 32'h2, 32'h0);
      tbl[7]  = mk(0, 0, 32'h0,  2'b01, 0, 2'b01, 2'b00, 2'b10, 2'b01, 32'h3, 32'h0);
      tbl[8]  = mk(0, 0, 32'h0,  2'b01, 0, 2'b01, 2'b00, 2'b10, 2'b01, 32'h4, 32'h0);
      tbl[9]  = mk(0, 0, 32'h0,  2'b01, 0, 2'b00, 2'b00, 2'b11, 2'b01, 32'h0, 32'h0);
      tbl[10] = mk(0, 0, 32'h0,  2'b00, 1, 2'b00, 2'b00, 2'b11, 2'b00, 32'h0, 32'h0);
      tbl[11] = mk(1, 0, 32'h6,  2'b00, 0, 2'b01, 2'b00, 2'b10, 2'b00, 32'h6, 32'h0);
      tbl[12] = mk(1, 0, 32'h7,  2'b00, 0, 2'b01, 2'b00, 2'b10, 2'b00, 32'h6, 32'h0);
      tbl[13] = mk(1, 0, 32'h8,  2'b00, 0, 2'b01, 2'b00, 2'b10, 2'b00, 32'h6, 32'h0);
      tbl[14] = mk(1, 0, 32'h9,  2'b00, 0, 2'b01, 2'b01, 2'b10, 2'b00, 32'h6, 32'h0);
      tbl[15] = mk(1, 0, 32'hA,  2'b01, 0, 2'b01, 2'b01, 2'b10, 2'b00, 32'h7, 32'h0);
      tbl[16] = mk(1, 7, 32'hBB, 2'b00, 0, 2'b01, 2'b01, 2'b10, 2'b00, 32'h7, 32'h0);
      tbl[17] = mk(1, 1, 32'hC1, 2'b00, 0, 2'b11, 2'b01, 2'b00, 2'b00, 32'h7, 32'hC1);
      tbl[18] = mk(0, 0, 32'h0,  2'b11, 0, 2'b01, 2'b00, 2'b10, 2'b00, 32'h8, 32'h0);
      tbl[19] = mk(0, 0, 32'h0,  2'b01, 0, 2'b01, 2'b00, 2'b10, 2'b00, 32'h9, 32'h0);
      tbl[20] = mk(0, 0, 32'h0,  2'b01, 0, 2'b01, 2'b00, 2'b10, 2'b00, 32'hA, 32'h0);
      tbl[21] = mk(0, 0, 32'h0,  2'b01, 0, 2'b00, 2'b00, 2'b11, 2'b00, 32'h0, 32'h0);
      tbl[22] = mk(1, 1, 32'h55, 2'b10, 0, 2'b10, 2'b00, 2'b01, 2'b00, 32'h0, 32'h55);
      tbl[23] = mk(0, 0, 32'h0,  2'b10, 0, 2'b00, 2'b00, 2'b11, 2'b00, 32'h0, 32'h0);

      movf = '0;
      for (int c = 0; c < CH; c++) mlast[c] = '0;
      bus.Out_portIn = 1'b0;
      bus.out_sel    = '0;
      bus.BusMuxOut  = '0;
      bus.dev_ready  = '0;
      bus.ovf_clr    = 1'b0;
      clear          = 1'b1;

      step(0, 0, 0, 2'b00, 0, 1);
      step(0, 0, 0, 2'b00, 0, 1);
      check("rst_valid", 64'(bus.dev_valid), 64'(2'b00));
      check("rst_empty", 64'(bus.port_empty), 64'(2'b11));
      check("rst_full",  64'(bus.port_full), 64'(2'b00));
      check("rst_ovf",   64'(bus.port_ovf), 64'(2'b00));
      check("rst_data",  64'(bus.dev_data), 64'(0));

      for (int i = 0; i < 24; i++) begin
         step(tbl[i].we, tbl[i].sel, tbl[i].d, tbl[i].rdy, tbl[i].oc, 0);
         check($sformatf("vec%0d_valid", i), 64'(bus.dev_valid), 64'(tbl[i].v));
         check($sformatf("vec%0d_full", i),  64'(bus.port_full), 64'(tbl[i].f));
         check($sformatf("vec%0d_empty", i), 64'(bus.port_empty), 64'(tbl[i].e));
         check($sformatf("vec%0d_ovf", i),   64'(bus.port_ovf), 64'(tbl[i].o));
         if (tbl[i].v[0]) check($sformatf("vec%0d_d0", i), 64'(bus.dev_data[0 +: W]), 64'(tbl[i].d0));
         if (tbl[i].v[1]) check($sformatf("vec%0d_d1", i), 64'(bus.dev_data[W +: W]), 64'(tbl[i].d1));
      end

      // drop and ovf_clr in the same cycle: the set must win
      for (int i = 0; i < DP; i++) step(1, 0, 32'h11 + 32'(i), 2'b00, 0, 0);
      step(1, 0, 32'h15, 2'b00, 1, 0);
      check("ovf_set_wins", 64'(bus.port_ovf), 64'(2'b01));
      step(0, 0, 0, 2'b00, 1, 0);
      check("ovf_clr", 64'(bus.port_ovf), 64'(2'b00));
      step(1, 0, 32'h15, 2'b00, 0, 0);
      check("ovf_reset_drop", 64'(bus.port_ovf), 64'(2'b01));
      step(1, 0, 32'h99, 2'b11, 0, 1);
      check("clr_wr_empty", 64'(bus.port_empty), 64'(2'b11));
      check("clr_wr_valid", 64'(bus.dev_valid), 64'(2'b00));
      check("clr_wr_ovf",   64'(bus.port_ovf), 64'(2'b00));
      check("clr_wr_data",  64'(bus.dev_data), 64'(0));

      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(0, 1)), SW'($urandom_range(0, 3)), $urandom,
              CH'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0), 0);

      step(1, 1, 32'hDEAD, 2'b11, 0, 1);
      check("mid_clr_valid", 64'(bus.dev_valid), 64'(2'b00));
      check("mid_clr_empty", 64'(bus.port_empty), 64'(2'b11));
      check("mid_clr_ovf",   64'(bus.port_ovf), 64'(2'b00));
      check("mid_clr_data",  64'(bus.dev_data), 64'(0));
      step(0, 0, 0, 2'b00, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
